// File: rtl/spi_frame_sender.sv
// SPI master (mode 0) that streams one frame from the pixel store to the display receiver.
// Per row: command 0xF0|row followed by every column's pixel word, MSB byte first.
// After the last row a single end command 0x10 tells the receiver to flip buffers.
// All SPI pins and control strobes are registered decodes of the next state.
module spi_frame_sender #(
  parameter int unsigned Segments = 1,
  parameter int unsigned Rows     = 8,
  parameter int unsigned Columns  = 32,
  parameter int unsigned ClkDiv   = 4,
  localparam int unsigned W       = Segments * 24,
  localparam int unsigned RowW    = (Rows > 1) ? $clog2(Rows) : 1,
  localparam int unsigned ColW    = (Columns > 1) ? $clog2(Columns) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            ren_o,
  output logic [RowW-1:0] rrow_o,
  output logic [ColW-1:0] rcol_o,
  input  logic [W-1:0]    rdata_i,
  output logic            sclk_o,
  output logic            ss_o,
  output logic            mosi_o,
  input  logic            miso_i
);

  localparam int unsigned Bytes = Segments * 3;
  localparam int unsigned ByteW = $clog2(Bytes) + 1;
  localparam int unsigned CntW  = $clog2(2 * ClkDiv) + 1;

  localparam logic [CntW-1:0]  CntHalf    = CntW'(ClkDiv);
  localparam logic [CntW-1:0]  CntTailEnd = CntW'(ClkDiv - 1);
  localparam logic [CntW-1:0]  CntBitEnd  = CntW'(2 * ClkDiv - 1);
  localparam logic [ByteW-1:0] LastByte   = ByteW'(Bytes - 1);
  localparam logic [RowW-1:0]  LastRow    = RowW'(Rows - 1);
  localparam logic [ColW-1:0]  LastCol    = ColW'(Columns - 1);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StSel    = 4'd1;
  localparam logic [3:0] StFetch  = 4'd2;
  localparam logic [3:0] StLatch  = 4'd3;
  localparam logic [3:0] StShift  = 4'd4;
  localparam logic [3:0] StTail   = 4'd5;
  localparam logic [3:0] StGap    = 4'd6;
  localparam logic [3:0] StEndCmd = 4'd7;
  localparam logic [3:0] StFin    = 4'd8;

  // miso is part of the physical link but carries nothing this master needs.
  logic unused_miso;
  assign unused_miso = miso_i;

  logic [3:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;     // phase counter within a bit / tail / gap
  logic [2:0]       bit_q, bit_d;     // bit index within the current byte
  logic [ByteW-1:0] byte_q, byte_d;   // byte index within the current pixel word
  logic [RowW-1:0]  row_q, row_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [7:0]       sh_q, sh_d;       // byte on the wire, bit 7 drives mosi
  logic [W-1:0]     wsh_q, wsh_d;     // remaining bytes of the pixel word, MSB aligned
  logic             cmd_q, cmd_d;     // current byte is a command byte
  logic             end_q, end_d;     // current transaction is the end command

  logic sclk_q, sclk_d;
  logic ss_q, ss_d;
  logic mosi_q, mosi_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ren_q, ren_d;

  // Next-state sequencing of the frame: rows, columns, bytes, bits and bit phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    row_d   = row_q;
    col_d   = col_q;
    sh_d    = sh_q;
    wsh_d   = wsh_q;
    cmd_d   = cmd_q;
    end_d   = end_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          row_d   = '0;
          col_d   = '0;
          end_d   = 1'b0;
          state_d = StSel;
        end
      end

      StSel: begin
        sh_d    = 8'hF0 | 8'(row_q);
        cmd_d   = 1'b1;
        bit_d   = '0;
        cnt_d   = '0;
        col_d   = '0;
        state_d = StShift;
      end

      StEndCmd: begin
        sh_d    = 8'h10;
        cmd_d   = 1'b1;
        end_d   = 1'b1;
        bit_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end

      StFetch: begin
        state_d = StLatch;
      end

      // rdata is valid in this cycle: first byte goes straight to the shifter.
      StLatch: begin
        sh_d    = rdata_i[W-1 -: 8];
        wsh_d   = rdata_i << 8;
        byte_d  = '0;
        bit_d   = '0;
        cnt_d   = '0;
        cmd_d   = 1'b0;
        state_d = StShift;
      end

      StShift: begin
        if (cnt_q == CntBitEnd) begin
          cnt_d = '0;
          if (bit_q != 3'd7) begin
            bit_d = bit_q + 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
          end else begin
            bit_d = '0;
            if (cmd_q) begin
              state_d = end_q ? StTail : StFetch;
            end else if (byte_q != LastByte) begin
              byte_d = byte_q + ByteW'(1);
              sh_d   = wsh_q[W-1 -: 8];
              wsh_d  = wsh_q << 8;
            end else if (col_q != LastCol) begin
              col_d   = col_q + ColW'(1);
              state_d = StFetch;
            end else begin
              state_d = StTail;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StTail: begin
        if (cnt_q == CntTailEnd) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StGap: begin
        if (cnt_q == CntBitEnd) begin
          cnt_d = '0;
          if (end_q) begin
            state_d = StFin;
          end else if (row_q != LastRow) begin
            row_d   = row_q + RowW'(1);
            state_d = StSel;
          end else begin
            state_d = StEndCmd;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StFin: begin
        row_d   = '0;
        col_d   = '0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state so every pin leaves a flop.
  always_comb begin
    ss_d   = (state_d == StShift) || (state_d == StFetch) ||
             (state_d == StLatch) || (state_d == StTail);
    sclk_d = (state_d == StShift) && (cnt_d >= CntHalf);
    // mosi only moves at the start of a bit; it holds through FETCH/LATCH/TAIL.
    if (state_d == StShift) begin
      mosi_d = sh_d[7];
    end else if (ss_d) begin
      mosi_d = mosi_q;
    end else begin
      mosi_d = 1'b0;
    end
    busy_d = (state_d != StIdle) && (state_d != StFin);
    done_d = (state_d == StFin);
    ren_d  = (state_d == StFetch);
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sh_q    <= '0;
      wsh_q   <= '0;
      cmd_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sh_q    <= sh_d;
      wsh_q   <= wsh_d;
      cmd_q   <= cmd_d;
      end_q   <= end_d;
    end
  end

  // Registered SPI pins and control strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_q <= 1'b0;
      ss_q   <= 1'b0;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ren_q  <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      ss_q   <= ss_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ren_q  <= ren_d;
    end
  end

  assign sclk_o = sclk_q;
  assign ss_o   = ss_q;
  assign mosi_o = mosi_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ren_o  = ren_q;
  assign rrow_o = row_q;
  assign rcol_o = col_q;

endmodule

// File: tb/tb_spi_frame_sender.sv
// Bench for spi_frame_sender: random pixel frames, scoreboard of expected wire bytes and
// ss-window lengths, decoupled SPI monitor, read-order and timing checks, start filtering
// and mid-frame reset.
module tb_spi_frame_sender;

  localparam int unsigned Segments = 2;
  localparam int unsigned Rows     = 2;
  localparam int unsigned Columns  = 3;
  localparam int unsigned ClkDiv   = 4;
  localparam int unsigned W        = Segments * 24;
  localparam int unsigned Bytes    = Segments * 3;
  localparam int unsigned RowW     = $clog2(Rows);
  localparam int unsigned ColW     = $clog2(Columns);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            miso;
  logic            busy, done, ren, sclk, ss, mosi;
  logic [RowW-1:0] rrow;
  logic [ColW-1:0] rcol;
  logic [W-1:0]    rdata;

  always #5 clk = ~clk;

  spi_frame_sender #(
    .Segments(Segments),
    .Rows    (Rows),
    .Columns (Columns),
    .ClkDiv  (ClkDiv)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .busy_o (busy),
    .done_o (done),
    .ren_o  (ren),
    .rrow_o (rrow),
    .rcol_o (rcol),
    .rdata_i(rdata),
    .sclk_o (sclk),
    .ss_o   (ss),
    .mosi_o (mosi),
    .miso_i (miso)
  );

  logic [W-1:0] mem [Rows][Columns];
  logic [7:0]   exp_q[$];
  int           exp_len_q[$];

  int checks = 0;
  int failures = 0;
  int ren_cnt = 0;
  int read_idx = 0;
  int bytes_seen = 0;
  int done_cnt = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Pixel store: word valid one clock after ren, garbage otherwise.
  always @(posedge clk) begin
    if (ren && rrow < Rows && rcol < Columns) rdata <= mem[rrow][rcol];
    else rdata <= W'({$urandom, $urandom});
  end

  // Reads must walk row-major through the frame, only while selected.
  always @(negedge clk) begin
    if (!rst && ren) begin
      check(ss === 1'b1, "ren_under_ss", ss, 1);
      check(rrow == RowW'(read_idx / Columns), "read_row", rrow, read_idx / Columns);
      check(rcol == ColW'(read_idx % Columns), "read_col", rcol, read_idx % Columns);
      read_idx++;
      ren_cnt++;
    end
  end

  // SPI monitor: decodes bytes on sclk rises and compares against the scoreboard.
  logic       sclk_p = 1'b0, ss_p = 1'b0, mosi_p = 1'b0;
  logic [7:0] sr = '0;
  logic [7:0] eb;
  int         el;
  int         cyc = 0, ss_rise_t = 0, ss_fall_t = -1, fall_t = 0, byte_t = 0;
  int         bitn = 0, win_bytes = 0;
  bit         first_rise = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sclk_p = 1'b0; ss_p = 1'b0; mosi_p = 1'b0;
      bitn = 0; win_bytes = 0; ss_fall_t = -1; first_rise = 1'b0;
    end else begin
      if (ss && !ss_p) begin
        if (ss_fall_t >= 0)
          check(cyc - ss_fall_t >= 2 * ClkDiv, "ss_low_gap", cyc - ss_fall_t, 2 * ClkDiv);
        ss_rise_t = cyc; first_rise = 1'b1; win_bytes = 0; bitn = 0;
      end
      if (!ss && ss_p) begin
        check(cyc - fall_t == ClkDiv, "ss_fall_delay", cyc - fall_t, ClkDiv);
        check(bitn == 0, "partial_byte", bitn, 0);
        check(exp_len_q.size() > 0, "window_expected", exp_len_q.size(), 1);
        if (exp_len_q.size() > 0) begin
          el = exp_len_q.pop_front();
          check(win_bytes == el, "window_bytes", win_bytes, el);
        end
        ss_fall_t = cyc;
      end
      if (sclk && !sclk_p) begin
        check(ss === 1'b1, "sclk_under_ss", ss, 1);
        if (first_rise) begin
          check(cyc - ss_rise_t == ClkDiv, "first_rise", cyc - ss_rise_t, ClkDiv);
          first_rise = 1'b0;
        end
        if (bitn == 0) byte_t = cyc;
        else if (bitn == 7) check(cyc - byte_t == 14 * ClkDiv, "byte_span", cyc - byte_t,
                                  14 * ClkDiv);
        sr = {sr[6:0], mosi};
        bitn++;
        if (bitn == 8) begin
          bitn = 0;
          win_bytes++;
          bytes_seen++;
          check(exp_q.size() > 0, "byte_expected", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            check(sr == eb, "wire_byte", sr, eb);
          end
        end
      end
      if (!sclk && sclk_p) fall_t = cyc;
      if (sclk && sclk_p) check(mosi === mosi_p, "mosi_stable_high", mosi, mosi_p);
      if (done) done_cnt++;
      sclk_p = sclk; ss_p = ss; mosi_p = mosi;
    end
  end

  // Reference frame: row commands, each word MSB byte first, then the end command.
  task automatic push_expected();
    logic [W-1:0] w;
    for (int r = 0; r < Rows; r++) begin
      exp_q.push_back(8'hF0 | 8'(r));
      for (int c = 0; c < Columns; c++) begin
        w = mem[r][c];
        for (int k = 0; k < Bytes; k++) exp_q.push_back(8'(w >> (8 * (Bytes - 1 - k))));
      end
      exp_len_q.push_back(1 + Columns * Bytes);
    end
    exp_q.push_back(8'h10);
    exp_len_q.push_back(1);
    ren_cnt = 0;
    read_idx = 0;
    done_cnt = 0;
  endtask

  task automatic fill_mem(input bit pattern);
    for (int r = 0; r < Rows; r++)
      for (int c = 0; c < Columns; c++)
        if (pattern) mem[r][c] = {8'(r), 8'(c), 8'h5A, 24'($urandom)};
        else mem[r][c] = W'({$urandom, $urandom});
    if (pattern) mem[0][0] = 48'h112233445566;
  endtask

  // Called at a negedge while idle; start is sampled at the following posedge.
  task automatic issue_start();
    check(busy == 1'b0, "idle_before_start", busy, 0);
    push_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(busy == 1'b1 && ss == 1'b0, "busy_rise", {busy, ss}, 2'b10);
    @(negedge clk);
    check(ss == 1'b1, "ss_rise", ss, 1);
  endtask

  // Returns at the negedge where done is high; optionally pokes start while busy.
  task automatic wait_done(input bit poke);
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (poke) start = ($urandom_range(0, 7) == 0);
    end
    check(ok, "done_seen", ok, 1);
    check(busy == 1'b0, "busy_low_at_done", busy, 0);
  endtask

  // Checks one negedge after done.
  task automatic after_frame_checks();
    check(done == 1'b0, "done_one_cycle", done, 0);
    check(done_cnt == 1, "done_pulses", done_cnt, 1);
    check(ren_cnt == Rows * Columns, "ren_count", ren_cnt, Rows * Columns);
    check(exp_q.size() == 0, "bytes_left", exp_q.size(), 0);
    check(exp_len_q.size() == 0, "windows_left", exp_len_q.size(), 0);
  endtask

  task automatic quiet_window(input string name, input int n);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ss || sclk || busy || ren || mosi) act++;
    end
    check(act == 0, name, act, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    miso = 1'b0;
    fill_mem(1'b1);
    repeat (3) @(negedge clk);
    check({busy, done, ren, sclk, ss, mosi, rrow, rcol} == '0, "reset_values",
          {busy, done, ren, sclk, ss, mosi, rrow, rcol}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      miso = 1'($urandom);
    end

    // Frame 1: row/col pattern plus the byte-order word at (0,0).
    issue_start();
    wait_done(1'b0);
    @(negedge clk);
    after_frame_checks();

    // Frame 2: random data, start poked while busy and held through the done cycle.
    fill_mem(1'b0);
    repeat (3) @(negedge clk);
    issue_start();
    wait_done(1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    after_frame_checks();
    quiet_window("start_with_done_ignored", 40);

    // Frames 3 and 4: a start the cycle after done begins the next frame.
    fill_mem(1'b0);
    issue_start();
    wait_done(1'b0);
    fill_mem(1'b0);
    @(negedge clk);
    after_frame_checks();
    issue_start();
    wait_done(1'b0);
    @(negedge clk);
    after_frame_checks();

    // Mid-frame reset while shifting a data byte.
    fill_mem(1'b0);
    repeat (2) @(negedge clk);
    issue_start();
    begin
      int base = bytes_seen;
      bit hit = 1'b0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk);
        if (bytes_seen >= base + 5) begin
          hit = 1'b1;
          break;
        end
      end
      check(hit, "reached_mid_frame", hit, 1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check({busy, done, ren, sclk, ss, mosi, rrow, rcol} == '0, "reset_abort",
          {busy, done, ren, sclk, ss, mosi, rrow, rcol}, 0);
    exp_q.delete();
    exp_len_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    quiet_window("idle_after_reset", 60);

    // Recovery frame after reset.
    fill_mem(1'b1);
    issue_start();
    wait_done(1'b0);
    @(negedge clk);
    after_frame_checks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_frame_sender.md
# spi_frame_sender

SPI master that streams one full frame from a local pixel store into the display controller's SPI receiver. Per row it sends a load-row transaction (command byte 0xF0|row, then every column's pixel word); after the last row it sends the one-byte end command 0x10, which tells the receiver to flip its buffer. It sits on the host/GPS-clock side of the SPI link, between the frame renderer's pixel memory and the display board.

## Interface
- segments, 1, number of daisy-chained panel segments; pixel word = segments*3 bytes
- rows, 8, addressable rows per frame (1..16; row number is carried in the low command nibble)
- columns, 32, columns per row
- clkdiv, 4, sclk half-period in clk cycles (>= 2)

- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to send a frame; ignored while busy
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the end transaction has completed
- ren  output  1  pixel read strobe, one cycle
- rrow  output  $clog2(rows)  pixel read row address
- rcol  output  $clog2(columns)  pixel read column address
- rdata  input  segments*24  pixel word; valid exactly one clk after ren
- sclk  output  1  SPI clock, idle low
- ss  output  1  SPI select, active-high (1 = selected), idle low
- mosi  output  1  SPI data out, MSB first
- miso  input  1  unused, ignored

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high. During and after reset: busy=0, done=0, ren=0, rrow=0, rcol=0, sclk=0, ss=0, mosi=0, FSM in IDLE. Reset mid-frame aborts immediately; no trailing bits are sent.
- SPI mode 0: mosi changes only while sclk low; receiver samples on sclk rising. Each bit = clkdiv cycles sclk low (mosi valid) then clkdiv cycles sclk high; one byte = 16*clkdiv cycles.
- States: IDLE, SEL, FETCH, LATCH, SHIFT, TAIL, GAP, ENDCMD, FIN.
- IDLE: on start, row=0 -> SEL.
- SEL: ss=1, load shift byte 0xF0|row, mosi=bit7 in the same cycle -> SHIFT.
- After the command byte, for col = 0..columns-1: FETCH (ren=1, rrow=row, rcol=col, sclk low) -> LATCH (capture rdata into word register) -> SHIFT the segments*3 bytes, byte k = rdata[W-1-8k -: 8] (most significant byte first), back-to-back.
- After the last byte of the last column: TAIL (sclk low, ss=1 for clkdiv cycles) -> GAP (ss=0 for 2*clkdiv cycles). If row < rows-1: row+1 -> SEL; else -> ENDCMD.
- ENDCMD: ss=1, shift 0x10, TAIL, GAP, then FIN: done=1 for one cycle, busy=0 -> IDLE.
- Transaction byte counts: load-row = 1 + columns*segments*3; end = 1. Frame = rows load-row transactions + 1 end transaction, strictly in row order 0..rows-1.
- miso never affects behaviour.

## Timing
- start accepted in IDLE only; busy rises the next cycle; ss rises the cycle after that (SEL).
- First sclk rising edge of every transaction is clkdiv cycles after ss rises.
- Exactly 2 extra sclk-low cycles (FETCH, LATCH) precede each column's first byte; no other inter-byte gaps within a transaction.
- ss falls clkdiv cycles after the final sclk falling edge; ss stays low >= 2*clkdiv cycles between transactions.
- ren high exactly columns times per row, once per column, never while ss=0.
- done asserts the cycle after the end transaction's GAP completes; start in that same cycle is ignored; start on the following cycle is accepted.
- sclk, ss, mosi are registered outputs (glitch-free).

## Test plan
- Reset values: assert rst mid-SHIFT -> same cycle ss=0, sclk=0, mosi=0, busy=0, ren=0; after release, no SPI activity until start.
- Small frame (rows=2, columns=2, segments=1, clkdiv=2), memory word = {row, col, 0x5A}: SPI monitor decodes F0 00 00 5A 00 01 5A | F1 01 00 5A 01 01 5A | 10, three ss windows, then one done pulse.
- Byte order (segments=2, word 0x112233445566): bytes on wire 11 22 33 44 55 66 after the command byte.
- Timing (clkdiv=4): ss-rise to first sclk rise = 4 cycles; byte = 64 cycles; ss-low gap >= 8 cycles; ren count = rows*columns.
- start while busy and start coincident with done -> ignored, exactly one frame sent; start one cycle after done -> second frame begins.
- Loopback into the display controller's SPI receiver: after the frame, every written (wrow, wcol, wdata) matches memory and loaded pulses once.
